// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared state encoding and counter widths for the SDRAM arbiter.
// Revision : 1.0
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_ISSUE = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    localparam int c_outst_w   = 4;
    localparam int c_run_w     = 8;
    localparam int c_outst_sat = (1 << c_outst_w) - 1;

endpackage
`default_nettype wire

// File: rtl/sat_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_updown_counter
// Brief    : Up/down counter saturating at 0 and MAX; inc+dec together hold.
// Revision : 1.0
// ============================================================================
module sat_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count < WIDTH'(MAX)) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : Read-priority arbiter sharing one SDRAM master port between a
//            write requester and a read requester, with a starvation guard.
// Revision : 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RD_RUN_MAX      = 8
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy
);

    arb_state_t           r_state;
    logic [c_outst_w-1:0] w_outstanding;
    logic [c_run_w-1:0]   w_run_cnt;
    logic                 w_rd_eligible;
    logic                 w_grant_rd;
    logic                 w_grant_wr;
    logic                 w_rd_accept;

    assign w_rd_eligible = rd_req && (w_outstanding < c_outst_w'(MAX_OUTSTANDING));
    // A pending write wins over reads once the read run has hit its limit.
    assign w_grant_wr    = (r_state == IDLE) && wr_req &&
                           (!w_rd_eligible || (w_run_cnt == c_run_w'(RD_RUN_MAX)));
    assign w_grant_rd    = (r_state == IDLE) && w_rd_eligible && !w_grant_wr;
    assign w_rd_accept   = (r_state == RD_ISSUE) && !avm_waitrequest;
    assign busy          = (r_state != IDLE);

    sat_updown_counter #(
        .WIDTH (c_outst_w),
        .MAX   (c_outst_sat)
    ) u_outstanding (
        .clk   (in_clk),
        .rst   (in_reset),
        .clr   (1'b0),
        .inc   (w_rd_accept),
        .dec   (avm_readdatavalid),
        .count (w_outstanding)
    );

    sat_updown_counter #(
        .WIDTH (c_run_w),
        .MAX   (RD_RUN_MAX)
    ) u_run_cnt (
        .clk   (in_clk),
        .rst   (in_reset),
        .clr   (w_grant_wr || !wr_req),
        .inc   (w_grant_rd && wr_req),
        .dec   (1'b0),
        .count (w_run_cnt)
    );

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state       <= IDLE;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            wr_ack        <= 1'b0;
            rd_ack        <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
        end else begin
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_valid <= avm_readdatavalid;
            rd_data  <= avm_readdata;
            case (r_state)
                IDLE: begin
                    if (w_grant_rd) begin
                        avm_address <= rd_addr;
                        avm_read    <= 1'b1;
                        r_state     <= RD_ISSUE;
                    end else if (w_grant_wr) begin
                        avm_address   <= wr_addr;
                        avm_writedata <= wr_data;
                        avm_write     <= 1'b1;
                        r_state       <= WR_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        rd_ack   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                WR_ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        wr_ack    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Scoreboard bench: expected master-port events queued with cycle stamps.
// Revision : 1.0
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int K_WR_CMD  = 0;
    localparam int K_RD_CMD  = 1;
    localparam int K_WR_ACK  = 2;
    localparam int K_RD_ACK  = 3;
    localparam int K_RD_DATA = 4;

    typedef struct {
        int          kind;
        logic [24:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    logic        in_clk = 1'b0;
    logic        in_reset;
    logic        wr_req, rd_req;
    logic [24:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        wr_ack, rd_ack, rd_valid;
    logic [15:0] rd_data;
    logic [24:0] avm_address;
    logic        avm_read, avm_write;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [15:0] avm_readdata;
    logic        busy;

    int  cyc = 0;
    int  vectors = 0;
    int  errors = 0;
    ev_t sb[$];

    sdram_port_arbiter #(
        .ADDR_W(25), .DATA_W(16), .MAX_OUTSTANDING(4), .RD_RUN_MAX(8)
    ) dut (
        .in_clk(in_clk), .in_reset(in_reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata),
        .busy(busy)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input int k, input logic [24:0] a, input logic [15:0] d, input int cy);
        sb.push_back('{k, a, d, cy});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_event(input int k, input logic [24:0] a, input logic [15:0] d);
        int idx;
        idx = -1;
        vectors++;
        foreach (sb[i]) if (idx < 0 && sb[i].kind == k && sb[i].cyc == cyc) idx = i;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected event kind %0d at cycle %0d addr=%0h data=%0h, expected none", k, cyc, a, d);
        end else begin
            if ((k == K_WR_CMD || k == K_RD_CMD) && a !== sb[idx].addr) begin
                errors++;
                $display("FAIL cmd address kind %0d cycle %0d: got %0h, expected %0h", k, cyc, a, sb[idx].addr);
            end else if ((k == K_WR_CMD || k == K_RD_DATA) && d !== sb[idx].data) begin
                errors++;
                $display("FAIL data kind %0d cycle %0d: got %0h, expected %0h", k, cyc, d, sb[idx].data);
            end
            sb.delete(idx);
        end
    endtask

    // Monitor: every observable master-port event must match a queued expectation.
    initial begin
        forever begin
            @(negedge in_clk);
            if ((avm_write === 1'b1 || avm_read === 1'b1) && avm_waitrequest === 1'b0)
                check_event(avm_write ? K_WR_CMD : K_RD_CMD, avm_address, avm_writedata);
            if (wr_ack === 1'b1)   check_event(K_WR_ACK, '0, '0);
            if (rd_ack === 1'b1)   check_event(K_RD_ACK, '0, '0);
            if (rd_valid === 1'b1) check_event(K_RD_DATA, '0, rd_data);
        end
    end

    task automatic wr_burst(input int n, input logic [24:0] base, input logic [15:0] d0);
        int k;
        k = 0;
        wr_addr = base; wr_data = d0; wr_req = 1'b1;
        for (int i = 0; i < 400 && k < n; i++) begin
            step();
            if (wr_ack) begin
                k++;
                if (k < n) begin
                    wr_addr = base + 25'(k); wr_data = d0 + 16'(k);
                end else wr_req = 1'b0;
            end
        end
        if (k < n) begin
            wr_req = 1'b0;
            chk("wr_ack timeout", 64'(k), 64'(n));
        end
    endtask

    task automatic rd_burst(input int n, input logic [24:0] base, input bit auto_ret);
        int k;
        k = 0;
        rd_addr = base; rd_req = 1'b1;
        for (int i = 0; i < 400 && k < n; i++) begin
            step();
            if (auto_ret) avm_readdatavalid = 1'b0;
            if (rd_ack) begin
                if (auto_ret) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = 16'hD000 + 16'(k);
                end
                k++;
                if (k < n) rd_addr = base + 25'(k);
                else rd_req = 1'b0;
            end
        end
        if (auto_ret) begin
            step();
            avm_readdatavalid = 1'b0;
        end
        if (k < n) begin
            rd_req = 1'b0;
            chk("rd_ack timeout", 64'(k), 64'(n));
        end
    endtask

    task automatic return_data(input logic [15:0] d);
        avm_readdatavalid = 1'b1;
        avm_readdata = d;
        push(K_RD_DATA, '0, d, cyc + 1);
        step();
        avm_readdatavalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        in_reset = 1'b1;
        wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
        step(); step();
        chk("reset outputs", 64'({avm_read, avm_write, avm_address, avm_writedata,
                                  wr_ack, rd_ack, rd_valid, rd_data, busy}), 64'd0);
        in_reset = 1'b0;
        step();

        // Single write with no stall
        c = cyc;
        push(K_WR_CMD, 25'h10, 16'hBEEF, c + 1);
        push(K_WR_ACK, '0, '0, c + 2);
        fork
            wr_burst(1, 25'h10, 16'hBEEF);
            begin
                step(); chk("busy write c+1", 64'(busy), 64'd1);
                step(); chk("busy write c+2", 64'(busy), 64'd1);
                step(); chk("busy write c+3", 64'(busy), 64'd0);
                chk("avm_write dropped", 64'(avm_write), 64'd0);
            end
        join
        step();

        // Read and write raised together: read first
        c = cyc;
        push(K_RD_CMD, 25'h20, '0, c + 1);
        push(K_RD_ACK, '0, '0, c + 2);
        push(K_WR_CMD, 25'h30, 16'h1234, c + 4);
        push(K_WR_ACK, '0, '0, c + 5);
        fork
            rd_burst(1, 25'h20, 1'b0);
            wr_burst(1, 25'h30, 16'h1234);
        join
        step();
        return_data(16'hA5A5);
        step();

        // Outstanding read limit: 5th read waits for a returned word
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            push(K_RD_CMD, 25'h100 + 25'(k), '0, c + 1 + 3 * k);
            push(K_RD_ACK, '0, '0, c + 2 + 3 * k);
        end
        push(K_RD_CMD, 25'h104, '0, c + 17);
        push(K_RD_ACK, '0, '0, c + 18);
        fork
            rd_burst(5, 25'h100, 1'b0);
            begin
                while (cyc < c + 14) step();
                chk("held 5th read busy", 64'(busy), 64'd0);
                chk("held 5th read avm_read", 64'(avm_read), 64'd0);
                step();
                return_data(16'hC0DE);
            end
        join
        for (int k = 0; k < 4; k++) return_data(16'hE000 + 16'(k));
        step();

        // Starvation guard: 8 reads, 1 write, repeating
        c = cyc;
        for (int k = 0; k < 8; k++) begin
            push(K_RD_CMD, 25'h200 + 25'(k), '0, c + 1 + 3 * k);
            push(K_RD_ACK, '0, '0, c + 2 + 3 * k);
            push(K_RD_DATA, '0, 16'hD000 + 16'(k), c + 3 + 3 * k);
            push(K_RD_CMD, 25'h208 + 25'(k), '0, c + 28 + 3 * k);
            push(K_RD_ACK, '0, '0, c + 29 + 3 * k);
            push(K_RD_DATA, '0, 16'hD008 + 16'(k), c + 30 + 3 * k);
        end
        push(K_WR_CMD, 25'h300, 16'hAAA0, c + 25);
        push(K_WR_ACK, '0, '0, c + 26);
        push(K_WR_CMD, 25'h301, 16'hAAA1, c + 52);
        push(K_WR_ACK, '0, '0, c + 53);
        push(K_RD_CMD, 25'h210, '0, c + 55);
        push(K_RD_ACK, '0, '0, c + 56);
        push(K_RD_DATA, '0, 16'hD010, c + 57);
        fork
            rd_burst(17, 25'h200, 1'b1);
            wr_burst(2, 25'h300, 16'hAAA0);
            begin
                while (cyc < c + 24) step();
                chk("run_cnt at limit", 64'(dut.w_run_cnt), 64'd8);
                step();
                chk("run_cnt after write 1", 64'(dut.w_run_cnt), 64'd0);
                while (cyc < c + 52) step();
                chk("run_cnt after write 2", 64'(dut.w_run_cnt), 64'd0);
            end
        join
        step();

        // Waitrequest stalls a write for 5 cycles
        c = cyc;
        push(K_WR_CMD, 25'h40, 16'h7777, c + 6);
        push(K_WR_ACK, '0, '0, c + 7);
        avm_waitrequest = 1'b1;
        fork
            wr_burst(1, 25'h40, 16'h7777);
            begin
                for (int i = 1; i <= 6; i++) begin
                    step();
                    if (i == 6) avm_waitrequest = 1'b0;
                    chk("stalled avm_write", 64'(avm_write), 64'd1);
                    chk("stalled avm_address", 64'(avm_address), 64'h40);
                end
                step();
                chk("avm_write after stall", 64'(avm_write), 64'd0);
            end
        join
        step();

        // Reset during a stalled write
        c = cyc;
        avm_waitrequest = 1'b1;
        wr_addr = 25'h50; wr_data = 16'h9999; wr_req = 1'b1;
        step();
        chk("write issued before reset", 64'(avm_write), 64'd1);
        step();
        in_reset = 1'b1;
        step();
        in_reset = 1'b0;
        avm_waitrequest = 1'b0;
        chk("outputs after mid reset", 64'({avm_read, avm_write, avm_address, avm_writedata,
                                            wr_ack, rd_ack, rd_valid, rd_data, busy}), 64'd0);
        push(K_WR_CMD, 25'h50, 16'h9999, c + 4);
        push(K_WR_ACK, '0, '0, c + 5);
        step(); step();
        wr_req = 1'b0;
        repeat (4) step();

        foreach (sb[i]) begin
            vectors++;
            errors++;
            $display("FAIL missing event kind %0d: expected at cycle %0d, never seen", sb[i].kind, sb[i].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

- Shares the single SDRAM controller master port between two requesters:
  - a write requester (image fill engine);
  - a read requester (VGA line fetch).
- Reads have priority. A starvation guard forces a write grant after a run of reads.
- Limits outstanding reads, registers all master-side command outputs and forwards read data back to the read requester.

## Interface
Parameters:
- ADDR_W, 25, SDRAM word address width
- DATA_W, 16, data width
- MAX_OUTSTANDING, 4, reads issued but not yet returned (1–15)
- RD_RUN_MAX, 8, consecutive read grants allowed while a write is pending (1–255)

Ports (one clock; reset is synchronous and active-high):
- in_clk  in  1  clock
- in_reset  in  1  synchronous active-high reset
- wr_req  in  1  write request; hold with wr_addr/wr_data stable until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write accepted by SDRAM
- rd_req  in  1  read request; hold with rd_addr stable until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  one-cycle pulse: read accepted
- rd_valid  out  1  read data valid
- rd_data  out  DATA_W  read data
- avm_address  out  ADDR_W  SDRAM command address
- avm_read  out  1  read command
- avm_write  out  1  write command
- avm_writedata  out  DATA_W  write data
- avm_waitrequest  in  1  controller stall
- avm_readdatavalid  in  1  returned data valid
- avm_readdata  in  DATA_W  returned data
- busy  out  1  state != IDLE

## Operation
- **States:** IDLE, RD_ISSUE, WR_ISSUE, DONE.
- **IDLE:** pick a requester and latch its address/data into the avm_* registers.
  - Read eligible: rd_req=1 and outstanding < MAX_OUTSTANDING.
  - Default order: read, then write.
  - Starvation guard: if run_cnt == RD_RUN_MAX and wr_req=1, grant the write even when a read is eligible.
  - Read granted → RD_ISSUE. Write granted → WR_ISSUE. Neither → stay in IDLE.
- **RD_ISSUE / WR_ISSUE:** hold avm_read or avm_write plus the latched values.
  - Cycle with avm_waitrequest=0 is the acceptance cycle.
  - Next cycle: command deasserted, state DONE, ack pulses.
- **DONE:** one cycle, then IDLE.
  - The requester may drop req or present a new address; the new address is sampled in the following IDLE.
- **outstanding counter:** 4 bits.
  - +1 on read acceptance, −1 on avm_readdatavalid; both in one cycle → unchanged.
  - Saturates at 0: a stray valid never underflows it.
- **run_cnt:** 8 bits.
  - +1 per read grant while wr_req=1, saturating at RD_RUN_MAX.
  - Cleared on a write grant and in any cycle with wr_req=0.
- **Read return:** rd_valid/rd_data = avm_readdatavalid/avm_readdata registered one cycle, always forwarded, including after a reset.
- **Reset values:** all outputs 0; state IDLE; outstanding, run_cnt and latches 0.
- **Reset mid-transaction:** command drops on the next edge, no ack is issued, and the requester must re-request.

## Timing
- Accepted command to ack: 1 cycle.
- Minimum 3 cycles per access (IDLE, ISSUE with waitrequest=0, DONE).
  - Each cycle of avm_waitrequest=1 adds one cycle.
- Read data latency: SDRAM latency + 1 cycle.
- A request asserted in a DONE cycle is first sampled in the next IDLE.
- A request deasserted before its ack, while in IDLE, is never granted.
  - Once granted, the transaction completes regardless of the req level.
- No combinational path from any input to any output.

## Structure
- Package sdram_arb_pkg holds:
  - state enum: IDLE=0, RD_ISSUE=1, WR_ISSUE=2, DONE=3;
  - counter width constants.
- One sub-module, sat_updown_counter: saturating inc/dec counter with simultaneous-event handling, parameterized width and max.
  - Used for both outstanding and run_cnt.

## Test plan
- Single write: wr_addr=0x00010, wr_data=0xBEEF, waitrequest=0.
  - avm_write is high for exactly one cycle with those values; wr_ack follows 1 cycle later; busy is high for 2 cycles.
- Both requests raised in the same cycle.
  - Read issued first, write second; rd_ack precedes wr_ack by 3 cycles.
- Read saturation: MAX_OUTSTANDING=4, no readdatavalid.
  - 4 reads issue; the 5th is held with rd_ack=0.
  - One readdatavalid pulse → 5th read issues 2 cycles later.
- Starvation: RD_RUN_MAX=8, rd_req and wr_req held high continuously.
  - Grant pattern is 8 reads then 1 write, repeating; run_cnt is 0 after each write.
- Waitrequest held high 5 cycles during a write.
  - avm_write and avm_address stay constant for 6 cycles; wr_ack 1 cycle after waitrequest falls.
- in_reset pulsed while in WR_ISSUE with waitrequest=1.
  - All outputs are 0 the next cycle; no wr_ack; arbitration resumes normally after reset.
